// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU op codes, RV32I opcode constants and decoded-entry type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b1000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SRA   = 4'b1101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_EQ    = 4'b1010,
    ALU_EQU   = 4'b1011,
    ALU_PASSB = 4'b1111
  } alu_op_e;

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] c_F7_BASE = 7'b0000000;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e     sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        invert;
    logic        branch;
    logic        illegal;
  } dec_t;

  // funct3 to ALU op for the funct7=0000000 flavour of OP / OP-IMM
  function automatic alu_op_e base_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decode_comb.sv
// ============================================================================
// Module   : alu_decode_comb
// Purpose  : Combinational RV32I decode into ALU op, operands and flags.
//            Branch decode is present only when ALU_DECODE_BRANCH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output dec_t        o_dec
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic        w_ok;
  dec_t        w_dec;
  logic        w_unused;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_unused = ^{i_instr[19:15], i_instr[11:7]};

  always_comb begin
    w_dec = '0;
    w_ok  = 1'b0;
    case (w_opcode)
      c_OPC_OP: begin
        w_dec.a = i_rs1;
        w_dec.b = i_rs2;
        if (w_funct7 == c_F7_BASE) begin
          w_dec.sel = base_op(w_funct3);
          w_ok      = 1'b1;
        end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b000) begin
          w_dec.sel = ALU_SUB;
          w_ok      = 1'b1;
        end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b101) begin
          w_dec.sel = ALU_SRA;
          w_ok      = 1'b1;
        end
      end
      c_OPC_OP_IMM: begin
        w_dec.a = i_rs1;
        w_dec.b = w_imm_i;
        case (w_funct3)
          3'b001: begin
            w_dec.sel = ALU_SLL;
            w_ok      = (w_funct7 == c_F7_BASE);
          end
          3'b101: begin
            w_dec.sel = (w_funct7 == c_F7_ALT) ? ALU_SRA : ALU_SRL;
            w_ok      = (w_funct7 == c_F7_BASE) || (w_funct7 == c_F7_ALT);
          end
          // funct3 000 is addi regardless of imm bits: there is no subi
          default: begin
            w_dec.sel = base_op(w_funct3);
            w_ok      = 1'b1;
          end
        endcase
      end
      c_OPC_LUI: begin
        w_dec.sel = ALU_PASSB;
        w_dec.b   = {i_instr[31:12], 12'h000};
        w_ok      = 1'b1;
      end
`ifdef ALU_DECODE_BRANCH_EN
      c_OPC_BRANCH: begin
        w_dec.a      = i_rs1;
        w_dec.b      = i_rs2;
        w_dec.branch = 1'b1;
        w_dec.invert = w_funct3[0];
        w_ok         = 1'b1;
        case (w_funct3)
          3'b000, 3'b001: w_dec.sel = ALU_EQ;
          3'b100, 3'b101: w_dec.sel = ALU_SLT;
          3'b110, 3'b111: w_dec.sel = ALU_SLTU;
          default:        w_ok      = 1'b0;
        endcase
      end
`endif
      default: ;
    endcase
    // Any illegal encoding collapses to a clean all-zero entry with the flag set
    if (!w_ok) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
  end

  assign o_dec = w_dec;

endmodule

`default_nettype wire

// File: rtl/alu_decode.sv
// ============================================================================
// Module   : alu_decode
// Purpose  : RV32I ALU decode stage with a 2-entry output FIFO (skid buffer).
//            Optional branch decode enabled by macro ALU_DECODE_BRANCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decode
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_select,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic        out_invert,
  output logic        out_branch,
  output logic        out_illegal
);

  dec_t       w_dec;
  dec_t       w_head;
  dec_t       r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  alu_decode_comb u_comb (
    .i_instr (in_instr),
    .i_rs1   (in_rs1),
    .i_rs2   (in_rs2),
    .o_dec   (w_dec)
  );

  // in_ready depends only on occupancy, so a full FIFO refuses even while draining
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign out_select  = w_head.sel;
  assign out_a       = w_head.a;
  assign out_b       = w_head.b;
  assign out_invert  = w_head.invert;
  assign out_branch  = w_head.branch;
  assign out_illegal = w_head.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_decode.sv
// ============================================================================
// Module   : tb_alu_decode
// Purpose  : Self-checking bench for alu_decode (directed vectors, back-pressure,
//            randomized scoreboard run, reset mid-operation).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_select;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_invert;
  logic        out_branch;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        inv;
    logic        br;
    logic        ill;
  } exp_t;

  logic [70:0] obs;
  assign obs = {out_select, out_a, out_b, out_invert, out_branch, out_illegal};

  always #5 clk = ~clk;

  alu_decode dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_select  (out_select),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_invert  (out_invert),
    .out_branch  (out_branch),
    .out_illegal (out_illegal)
  );

  // Reference decode: ALU code is {funct7[5], funct3} for OP/OP-IMM
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] rs1,
                                 input logic [31:0] rs2);
    exp_t       e;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       ok;
    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    e   = '0;
    ok  = 1'b0;
    if (opc == 7'h33) begin
      e.a   = rs1;
      e.b   = rs2;
      ok    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.sel = {f7[5], f3};
    end else if (opc == 7'h13) begin
      e.a = rs1;
      e.b = {{20{instr[31]}}, instr[31:20]};
      if (f3 == 3'd1) begin
        ok    = (f7 == 7'h00);
        e.sel = 4'b0001;
      end else if (f3 == 3'd5) begin
        ok    = (f7 == 7'h00) || (f7 == 7'h20);
        e.sel = {f7[5], 3'b101};
      end else begin
        ok    = 1'b1;
        e.sel = {1'b0, f3};
      end
    end else if (opc == 7'h37) begin
      ok    = 1'b1;
      e.sel = 4'hF;
      e.b   = {instr[31:12], 12'h000};
    end
`ifdef ALU_DECODE_BRANCH_EN
    else if (opc == 7'h63) begin
      e.a   = rs1;
      e.b   = rs2;
      e.br  = 1'b1;
      e.inv = f3[0];
      ok    = (f3 != 3'd2) && (f3 != 3'd3);
      e.sel = (f3 < 3'd2) ? 4'hA : ((f3 < 3'd6) ? 4'h2 : 4'h3);
    end
`endif
    if (!ok) begin
      e     = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    total++;
    if (obs !== 71'd0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", obs);
    end
  endtask

  task automatic test_directed();
    logic [31:0] v_instr [10];
    logic [31:0] v_rs1   [10];
    logic [31:0] v_rs2   [10];
    logic [70:0] v_exp   [10];
    v_instr[0] = 32'h002081B3; v_rs1[0] = 32'd5;         v_rs2[0] = 32'd7;
    v_exp[0]   = {4'h0, 32'd5, 32'd7, 3'b000};
    v_instr[1] = 32'h4030D093; v_rs1[1] = 32'h80000000;  v_rs2[1] = 32'h1234;
    v_exp[1]   = {4'hD, 32'h80000000, 32'h403, 3'b000};
    v_instr[2] = 32'h2030D093; v_rs1[2] = 32'h80000000;  v_rs2[2] = 32'h1234;
    v_exp[2]   = {4'h0, 32'd0, 32'd0, 3'b001};
    v_instr[3] = 32'h123450B7; v_rs1[3] = 32'd0;         v_rs2[3] = 32'h99;
    v_exp[3]   = {4'hF, 32'd0, 32'h12345000, 3'b000};
    v_instr[4] = 32'h0020D063; v_rs1[4] = 32'd3;         v_rs2[4] = 32'd9;
`ifdef ALU_DECODE_BRANCH_EN
    v_exp[4]   = {4'h2, 32'd3, 32'd9, 3'b110};
`else
    v_exp[4]   = {4'h0, 32'd0, 32'd0, 3'b001};
`endif
    v_instr[5] = 32'h00000003; v_rs1[5] = 32'd1;         v_rs2[5] = 32'd2;
    v_exp[5]   = {4'h0, 32'd0, 32'd0, 3'b001};
    v_instr[6] = 32'h402081B3; v_rs1[6] = 32'd10;        v_rs2[6] = 32'd3;
    v_exp[6]   = {4'h8, 32'd10, 32'd3, 3'b000};
    v_instr[7] = 32'hFFF00093; v_rs1[7] = 32'h10;        v_rs2[7] = 32'd4;
    v_exp[7]   = {4'h0, 32'h10, 32'hFFFFFFFF, 3'b000};
    v_instr[8] = 32'h402091B3; v_rs1[8] = 32'd1;         v_rs2[8] = 32'd2;
    v_exp[8]   = {4'h0, 32'd0, 32'd0, 3'b001};
    v_instr[9] = 32'h40009093; v_rs1[9] = 32'd1;         v_rs2[9] = 32'd2;
    v_exp[9]   = {4'h0, 32'd0, 32'd0, 3'b001};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_instr = v_instr[i];
      in_rs1   = v_rs1[i];
      in_rs2   = v_rs2[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL directed_%0d_valid got=%b want=1", i, out_valid);
      end
      total++;
      if (obs !== v_exp[i]) begin
        bad++;
        $display("FAIL directed_%0d_data got=%h want=%h", i, obs, v_exp[i]);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_instr = 32'h002081B3;
      in_rs1   = 32'd100 + 32'(i);
      in_rs2   = 32'd1;
      @(negedge clk);
      total++;
      if (in_ready !== (i < 2)) begin
        bad++;
        $display("FAIL b2b_in_ready_%0d got=%b want=%b", i, in_ready, (i < 2));
      end
      if (i > 0) begin
        total++;
        if (out_a !== 32'd100) begin
          bad++;
          $display("FAIL b2b_stall_hold_%0d got=%0d want=100", i, out_a);
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_a !== 32'd100 + 32'(j)) begin
        bad++;
        $display("FAIL b2b_drain_%0d got=%b/%0d want=1/%0d", j, out_valid, out_a, 100 + j);
      end
      @(posedge clk);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_empty got=%b want=0", out_valid);
    end
  endtask

  task automatic test_random();
    exp_t        q[$];
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [31:0] instr;
    logic        acc;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      case ($urandom_range(0, 4))
        0:       opc = 7'h33;
        1:       opc = 7'h13;
        2:       opc = 7'h37;
        3:       opc = 7'h63;
        default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      instr        = $urandom;
      instr[6:0]   = opc;
      instr[31:25] = f7;
      in_instr     = instr;
      in_rs1       = (opc == 7'h37) ? 32'd0 : $urandom;
      in_rs2       = $urandom;
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = (c > 580) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (c > 580) in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== (q.size() < 2)) begin
        bad++;
        $display("FAIL rand_in_ready c=%0d got=%b want=%b", c, in_ready, (q.size() < 2));
      end
      total++;
      if (out_valid !== (q.size() > 0)) begin
        bad++;
        $display("FAIL rand_out_valid c=%0d got=%b want=%b", c, out_valid, (q.size() > 0));
      end
      if (q.size() > 0) begin
        total++;
        if (obs !== q[0]) begin
          bad++;
          $display("FAIL rand_data c=%0d got=%h want=%h", c, obs, q[0]);
        end
      end
      acc = in_valid && (q.size() < 2);
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(model(in_instr, in_rs1, in_rs2));
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_instr = 32'h002081B3;
      in_rs1   = 32'hAA + 32'(i);
      in_rs2   = 32'h55;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_full got=%b/%b want=1/0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async got=%b want=0", out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs !== 71'd0) begin
        bad++;
        $display("FAIL rstmid_after_%0d got=%b/%b/%h want=1/0/0", k, in_ready, out_valid, obs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_decode.md
ALU_DECODE -- requirements
Module: alu_decode

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid  input  1; in_ready  output  1  (upstream instruction handshake).
REQ-004 SHALL have ports: in_instr  input  32  RV32I instruction; in_rs1  input  32; in_rs2  input  32  (register operands).
REQ-005 SHALL have ports: out_valid  output  1; out_ready  input  1  (downstream ALU-stage handshake).
REQ-006 SHALL have ports: out_select  output  4  ALU op code; out_a  output  32; out_b  output  32  (ALU operands).
REQ-007 SHALL have ports: out_invert  output  1  (branch sense inverted); out_branch  output  1; out_illegal  output  1.

Function
REQ-008 SHALL produce ALU codes: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111, eq 1010, equ 1011, passb 1111.
REQ-009 SHALL decode opcode 0110011 (OP) from funct3; funct7 0100000 selects sub (funct3 000) or sra (funct3 101); funct7 0000000 selects base op; any other funct7/funct3 pair flags illegal; out_b = in_rs2.
REQ-010 SHALL decode opcode 0010011 (OP-IMM) as OP with out_b = sign-extended instr[31:20]; funct3 000 never sub; slli needs funct7 0000000; srli/srai need funct7 0000000/0100000, else illegal.
REQ-011 SHALL decode opcode 0110111 (LUI) as passb, out_b = {instr[31:12], 12'b0}.
REQ-012 SHALL drive out_a = in_rs1 for every legal non-LUI op.
REQ-013 SHALL, for any unsupported opcode, set out_illegal=1, out_select=0000, out_a=out_b=0, out_branch=0, out_invert=0, and still transfer the entry downstream.
REQ-014 SHALL register all outputs: entry accepted in cycle N (in_valid & in_ready) appears with out_valid=1 in cycle N+1 at the earliest; latency exactly 1 when downstream not stalled.
REQ-015 SHALL contain a 2-entry FIFO (skid buffer); in_ready = not full; sustains one transfer per cycle with out_ready held high.
REQ-016 SHALL present entries in order; out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-017 SHALL, on simultaneous accept and drain when full, not accept (in_ready=0 that cycle); when one entry held, simultaneous accept and drain keeps occupancy 1.
REQ-018 SHALL pop only on out_valid & out_ready; out_ready while empty has no effect.

Reset
REQ-019 SHALL, on rst_n low, immediately clear occupancy: out_valid=0, in_ready=1 after reset release, all out_* data = 0.
REQ-020 SHALL discard buffered entries when reset asserts mid-operation; no partial entry emitted after release.

Configuration
REQ-021 SHALL honour macro ALU_DECODE_BRANCH_EN.
REQ-022 With ALU_DECODE_BRANCH_EN defined, opcode 1100011 decodes: BEQ eq/inv0, BNE eq/inv1, BLT slt/inv0, BGE slt/inv1, BLTU sltu/inv0, BGEU sltu/inv1, out_branch=1, out_b=in_rs2; funct3 010/011 illegal.
REQ-023 Without ALU_DECODE_BRANCH_EN, opcode 1100011 SHALL be illegal per REQ-013 and out_branch/out_invert tied 0.

Structure
REQ-024 SHALL place ALU op codes (REQ-008) and opcode constants in shared package alu_pkg, used by this block and the ALU.
REQ-025 SHALL implement the combinational decoder as sub-module alu_decode_comb; FIFO storage stays in alu_decode.

Verification
REQ-026 add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_select=0000, out_a=5, out_b=7, out_illegal=0.
REQ-027 srai (0x4030D093), rs1=0x80000000 -> out_select=1101, out_b=0x403; funct7=0x10 variant -> out_illegal=1, out_select=0000.
REQ-028 LUI 0x12345 (0x123450B7) -> out_select=1111, out_b=0x12345000.
REQ-029 out_ready=0 while 3 back-to-back valids -> 2 accepted, in_ready=0 on third; release -> outputs drained in order, one per cycle.
REQ-030 BGE (funct3 101) with macro -> out_select=0010, out_invert=1, out_branch=1; without macro -> out_illegal=1.
REQ-031 rst_n low with 2 entries buffered -> out_valid=0 immediately; after release in_ready=1, no stale output.
